// File: rtl/fir_pkt_pkg.sv
// Shared types and constants for the FIR packet source.
// Trailer layout, FSM encoding and the CRC-16-CCITT step function.
package fir_pkt_pkg;

   typedef enum logic [6:0] {
      IDLE        = 7'b000_0001,
      HDR_TYPE    = 7'b000_0010,
      HDR_SCAN_HI = 7'b000_0100,
      HDR_SCAN_LO = 7'b000_1000,
      DATA        = 7'b001_0000,
      CRC         = 7'b010_0000,
      TRAILER     = 7'b100_0000
   } states_t;

   localparam int HDR_WORDS   = 3;
   localparam int LEN_ERR_BIT = 0;
   localparam int OVF_BIT     = 1;
   localparam int DROP_LSB    = 2;
   localparam int DROP_W      = 14;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Folds one 16-bit word into the CRC, MSB first.
   function automatic logic [15:0] crc16_step(
      input logic [15:0] crc,
      input logic [15:0] d
   );
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ d[i])
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         else
            c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/fir_packet_tx_if.sv
// Avalon-ST packet output bundle (readyLatency 0).
// master drives the packet words, slave returns ready.
interface fir_packet_tx_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  ready;
   logic                  valid;
   logic                  startofpacket;
   logic                  endofpacket;
   logic [DATA_WIDTH-1:0] data;

   modport master (
      input  ready,
      output valid, startofpacket, endofpacket, data
   );

   modport slave (
      output ready,
      input  valid, startofpacket, endofpacket, data
   );
endinterface

// File: rtl/fir_pkt_fifo.sv
// Show-ahead synchronous sample FIFO with flush.
// A write while full is legal when a read happens in the same cycle.
module fir_pkt_fifo
   import fir_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wp;
   logic [AW-1:0]         rp;
   logic [AW:0]           cnt;

   assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
   assign empty   = (cnt == '0);
   assign rd_data = mem[rp];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wp] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr_en)
            wp <= wp + 1'b1;
         if (rd_en)
            rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end
endmodule

// File: rtl/fir_packet_tx.sv
// Frames streamed sensor samples into header/data/trailer packets.
// Define FIR_PACKET_TX_CRC_EN to append a CRC-16-CCITT word after data.
module fir_packet_tx
   import fir_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  cfg_length,
   input  logic [DATA_WIDTH-1:0] cfg_sensor_type,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic                  busy,
   fir_packet_tx_if.master       data_output
);
`ifdef FIR_PACKET_TX_CRC_EN
   localparam states_t POST_DATA = CRC;
`else
   localparam states_t POST_DATA = TRAILER;
`endif

   states_t state, state_nx;

   logic [LEN_WIDTH-1:0]  len_q, in_cnt, out_cnt, drop_cnt;
   logic [DATA_WIDTH-1:0] type_q;
   logic [31:0]           scan_count;
   logic                  ovf;

   logic                  o_valid, o_sop, o_eop;
   logic [DATA_WIDTH-1:0] o_data;

   logic                  ld, l_sop, l_eop;
   logic [DATA_WIDTH-1:0] l_data;
   logic                  accept, pop, scan_inc;
   logic                  xfer, done, in_win, samp_in;
   logic                  full, empty, wr_en, drop;
   logic [DATA_WIDTH-1:0] rd_data, trailer;
   logic [DROP_W-1:0]     drop_sat;
`ifdef FIR_PACKET_TX_CRC_EN
   logic [15:0]           crc;
`endif

   assign xfer    = o_valid & data_output.ready;
   assign busy    = (state != IDLE);
   assign in_win  = busy && (in_cnt != len_q);
   assign samp_in = in_win & sample_valid;
   assign wr_en   = samp_in & (~full | pop);
   assign drop    = samp_in & full & ~pop;
   assign done    = (out_cnt + drop_cnt) == len_q;

   assign drop_sat = (drop_cnt > LEN_WIDTH'({DROP_W{1'b1}})) ?
                     '1 : drop_cnt[DROP_W-1:0];

   always_comb begin
      trailer = '0;
      trailer[LEN_ERR_BIT] = (len_q == '0);
      trailer[OVF_BIT] = ovf;
      trailer[DROP_LSB +: DROP_W] = drop_sat;
   end

   fir_pkt_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (accept),
      .wr_en   (wr_en),
      .wr_data (sample_data),
      .rd_en   (pop),
      .full    (full),
      .empty   (empty),
      .rd_data (rd_data)
   );

   // Each state loads its word into the output register when it is
   // empty and advances once that word has been accepted.
   always_comb begin
      state_nx = state;
      ld       = 1'b0;
      l_sop    = 1'b0;
      l_eop    = 1'b0;
      l_data   = '0;
      accept   = 1'b0;
      pop      = 1'b0;
      scan_inc = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = HDR_TYPE;
            end
         end
         HDR_TYPE: begin
            if (xfer)
               state_nx = HDR_SCAN_HI;
            else if (!o_valid) begin
               ld     = 1'b1;
               l_sop  = 1'b1;
               l_data = type_q;
            end
         end
         HDR_SCAN_HI: begin
            if (xfer)
               state_nx = HDR_SCAN_LO;
            else if (!o_valid) begin
               ld     = 1'b1;
               l_data = DATA_WIDTH'(scan_count[31:16]);
            end
         end
         HDR_SCAN_LO: begin
            if (xfer)
               state_nx = DATA;
            else if (!o_valid) begin
               ld     = 1'b1;
               l_data = DATA_WIDTH'(scan_count[15:0]);
            end
         end
         DATA: begin
            if (xfer)
               pop = 1'b1;
            else if (!o_valid) begin
               if (done)
                  state_nx = POST_DATA;
               else if (!empty) begin
                  ld     = 1'b1;
                  l_data = rd_data;
               end
            end
         end
`ifdef FIR_PACKET_TX_CRC_EN
         CRC: begin
            if (xfer)
               state_nx = TRAILER;
            else if (!o_valid) begin
               ld     = 1'b1;
               l_data = DATA_WIDTH'(crc);
            end
         end
`endif
         TRAILER: begin
            if (xfer) begin
               state_nx = IDLE;
               scan_inc = 1'b1;
            end else if (!o_valid) begin
               ld     = 1'b1;
               l_eop  = 1'b1;
               l_data = trailer;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_sop   <= 1'b0;
         o_eop   <= 1'b0;
         o_data  <= '0;
      end else if (xfer) begin
         o_valid <= 1'b0;
         o_sop   <= 1'b0;
         o_eop   <= 1'b0;
      end else if (ld) begin
         o_valid <= 1'b1;
         o_sop   <= l_sop;
         o_eop   <= l_eop;
         o_data  <= l_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q    <= '0;
         type_q   <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (accept) begin
         len_q    <= cfg_length;
         type_q   <= cfg_sensor_type;
         in_cnt   <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (samp_in)
            in_cnt <= in_cnt + 1'b1;
         if (drop) begin
            drop_cnt <= drop_cnt + 1'b1;
            ovf      <= 1'b1;
         end
         if (pop)
            out_cnt <= out_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         scan_count <= '0;
      else if (scan_inc)
         scan_count <= scan_count + 32'd1;
   end

`ifdef FIR_PACKET_TX_CRC_EN
   always_ff @(posedge clk) begin
      if (reset || accept)
         crc <= CRC_INIT;
      else if (pop)
         crc <= crc16_step(crc, o_data[15:0]);
   end
`endif

   assign data_output.valid         = o_valid;
   assign data_output.startofpacket = o_sop;
   assign data_output.endofpacket   = o_eop;
   assign data_output.data          = o_data;
endmodule
